// File: rtl/rf_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rf_instr_decoder
// Description : Decode stage in front of the register-file functional unit.
//               It registers raw 16-bit RF instructions taken over a
//               valid/ready handshake. Each one is expanded into the 14-bit RF
//               control word, which is zero-extended to I_DECODED_WIDTH and
//               presented one cycle after acceptance. The block also handles
//               array-wide stalls and multi-cycle NOP repeats (NOPR), so the
//               RF never sees a duplicated write.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   iClk                 in   1                clock
//   iReset               in   1                asynchronous reset, active low
//   iInstr               in   I_WIDTH          raw instruction
//   iInstrValid          in   1                iInstr valid
//   oInstrReady          out  1                decoder can accept this cycle
//   iStall               in   1                array-wide stall
//   oDecodedInstruction  out  I_DECODED_WIDTH  control word to the RF
//   oDecodedValid        out  1                control word is a fresh, non-stalled
//                                              accepted instruction
//   oIllegal             out  1                sticky illegal-opcode flag
//                                              (RF_DEC_ILLEGAL_TRAP_EN builds only)
// Configuration macro
//   RF_DEC_ILLEGAL_TRAP_EN : when defined, opcode 111 raises oIllegal and
//                            parks the decoder in TRAP until reset. When it
//                            is undefined, opcode 111 decodes as a NOP.
// ============================================================================
module rf_instr_decoder #(
    parameter int I_WIDTH         = 16,
    parameter int I_DECODED_WIDTH = 16,
    parameter int REG_ADDR_WIDTH  = 4,
    parameter int SRC_WIDTH       = 2,
    parameter int DEST_WIDTH      = 1,
    parameter     TEST_ID         = "0"
) (
    input  logic                       iClk,
    input  logic                       iReset,
    input  logic [I_WIDTH-1:0]         iInstr,
    input  logic                       iInstrValid,
    output logic                       oInstrReady,
    input  logic                       iStall,
    output logic [I_DECODED_WIDTH-1:0] oDecodedInstruction,
    output logic                       oDecodedValid
`ifdef RF_DEC_ILLEGAL_TRAP_EN
    ,
    output logic                       oIllegal
`endif
);

    // Only the fixed field layout is implemented. The debug dump suffix must
    // be a non-empty string.
    generate
        if (I_WIDTH != 16 || I_DECODED_WIDTH < 14 || REG_ADDR_WIDTH != 4 ||
            SRC_WIDTH != 2 || DEST_WIDTH != 1 || $bits(TEST_ID) < 8) begin : g_bad_params
            $error("rf_instr_decoder: unsupported parameter set");
        end
    endgenerate

    localparam logic [2:0] cOpNop    = 3'b000;
    localparam logic [2:0] cOpRd     = 3'b001;
    localparam logic [2:0] cOpRdi    = 3'b010;
    localparam logic [2:0] cOpWr     = 3'b011;
    localparam logic [2:0] cOpWri    = 3'b100;
    localparam logic [2:0] cOpWriRdi = 3'b101;
    localparam logic [2:0] cOpNopr   = 3'b110;

`ifdef RF_DEC_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPEAT = 2'd1,
        TRAP   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPEAT = 2'd1
    } state_t;
`endif

    state_t      rState;
    logic [7:0]  rCount;
    logic [13:0] rDecoded;
    logic        rDecodedValid;

    // Raw instruction fields
    logic [2:0]  wOp;
    logic [3:0]  wRegB;
    logic        wRegA;
    logic        wDest;
    logic [1:0]  wSrcB;
    logic [1:0]  wSrcA;
    logic [7:0]  wNoprCnt;
    logic [2:0]  wunusedInstrLow;

    assign wOp             = iInstr[15:13];
    assign wRegB           = iInstr[12:9];
    assign wRegA           = iInstr[8];
    assign wDest           = iInstr[7];
    assign wSrcB           = iInstr[6:5];
    assign wSrcA           = iInstr[4:3];
    assign wNoprCnt        = iInstr[12:5];
    assign wunusedInstrLow = iInstr[2:0];

    logic        wRead;
    logic        wReadImm;
    logic        wWrite;
    logic        wWriteImm;
    logic        wCopyFields;
    logic        wIsNopr;
    logic [13:0] wDecoded;
`ifdef RF_DEC_ILLEGAL_TRAP_EN
    logic        wIsIllegal;
    logic        rIllegal;
`endif

    always_comb begin
        wRead       = 1'b0;
        wReadImm    = 1'b0;
        wWrite      = 1'b0;
        wWriteImm   = 1'b0;
        wCopyFields = 1'b1;
        wIsNopr     = 1'b0;
`ifdef RF_DEC_ILLEGAL_TRAP_EN
        wIsIllegal  = 1'b0;
`endif
        case (wOp)
            cOpRd:     wRead = 1'b1;
            cOpRdi:    begin wRead = 1'b1; wReadImm = 1'b1; end
            cOpWr:     wWrite = 1'b1;
            cOpWri:    wWriteImm = 1'b1;
            cOpWriRdi: begin wWriteImm = 1'b1; wRead = 1'b1; wReadImm = 1'b1; end
            cOpNop:    wCopyFields = 1'b0;
            cOpNopr:   begin wCopyFields = 1'b0; wIsNopr = 1'b1; end
            default: begin
                // Opcode 111: a NOP word. It traps only in trap-enabled builds.
                wCopyFields = 1'b0;
`ifdef RF_DEC_ILLEGAL_TRAP_EN
                wIsIllegal  = 1'b1;
`endif
            end
        endcase
        // NOP-class words are all zero, so the field bits are suppressed too.
        wDecoded = wCopyFields ?
                   {wRegB, wRegA, wRead, wReadImm, wWrite, wWriteImm, wDest, wSrcB, wSrcA} :
                   14'd0;
    end

    // A held word waits while a stall is active. During that time it has not
    // yet been presented to the RF, so no new instruction may overwrite it.
    logic wPending;
    logic wAccept;

    assign wPending    = rDecodedValid & iStall;
    assign oInstrReady = (rState == IDLE) & ~iStall & ~wPending;
    assign wAccept     = iInstrValid & oInstrReady;

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            rState        <= IDLE;
            rCount        <= 8'd0;
            rDecoded      <= 14'd0;
            rDecodedValid <= 1'b0;
`ifdef RF_DEC_ILLEGAL_TRAP_EN
            rIllegal      <= 1'b0;
`endif
        end else if (!iStall) begin
            // A presented word is cleared, unless a new word replaces it in
            // the same cycle. That rule gives one-per-cycle throughput and
            // also prevents a word from being written to the RF twice.
            if (wAccept) begin
                rDecoded      <= wDecoded;
                rDecodedValid <= 1'b1;
            end else begin
                rDecoded      <= 14'd0;
                rDecodedValid <= 1'b0;
            end

            case (rState)
                IDLE: begin
                    if (wAccept) begin
                        if (wIsNopr && wNoprCnt != 8'd0) begin
                            rState <= REPEAT;
                            rCount <= wNoprCnt;
                        end
`ifdef RF_DEC_ILLEGAL_TRAP_EN
                        else if (wIsIllegal) begin
                            rState   <= TRAP;
                            rIllegal <= 1'b1;
                        end
`endif
                    end
                end
                REPEAT: begin
                    // The last repeat cycle is the one where the count leaves 1.
                    if (rCount == 8'd1) begin
                        rState <= IDLE;
                        rCount <= 8'd0;
                    end else begin
                        rCount <= rCount - 8'd1;
                    end
                end
`ifdef RF_DEC_ILLEGAL_TRAP_EN
                TRAP: rState <= TRAP;
`endif
                default: begin
                    rState <= IDLE;
                    rCount <= 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        oDecodedInstruction = '0;
        if (!iStall) begin
            oDecodedInstruction[13:0] = rDecoded;
        end
    end

    assign oDecodedValid = ~iStall & rDecodedValid;

`ifdef RF_DEC_ILLEGAL_TRAP_EN
    assign oIllegal = rIllegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_instr_decoder
// Description : Directed, self-checking bench for rf_instr_decoder. Expected
//               control words are built from the instruction fields. They are
//               queued when an instruction is driven and popped whenever the
//               DUT flags a valid output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_instr_decoder;

    logic        iClk;
    logic        iReset;
    logic [15:0] iInstr;
    logic        iInstrValid;
    logic        oInstrReady;
    logic        iStall;
    logic [15:0] oDecodedInstruction;
    logic        oDecodedValid;
`ifdef RF_DEC_ILLEGAL_TRAP_EN
    logic        oIllegal;
`endif

    rf_instr_decoder #(
        .I_WIDTH         (16),
        .I_DECODED_WIDTH (16),
        .REG_ADDR_WIDTH  (4),
        .SRC_WIDTH       (2),
        .DEST_WIDTH      (1),
        .TEST_ID         ("0")
    ) dut (
        .iClk                (iClk),
        .iReset              (iReset),
        .iInstr              (iInstr),
        .iInstrValid         (iInstrValid),
        .oInstrReady         (oInstrReady),
        .iStall              (iStall),
        .oDecodedInstruction (oDecodedInstruction),
        .oDecodedValid       (oDecodedValid)
`ifdef RF_DEC_ILLEGAL_TRAP_EN
        ,
        .oIllegal            (oIllegal)
`endif
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [15:0] sbQ[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkInstr(input logic [2:0] op, input logic [3:0] rb,
                                            input logic ra, input logic d,
                                            input logic [1:0] sb, input logic [1:0] sa);
        return {op, rb, ra, d, sb, sa, 3'b101};
    endfunction

    function automatic logic [15:0] expWord(input logic [2:0] op, input logic [3:0] rb,
                                            input logic ra, input logic d,
                                            input logic [1:0] sb, input logic [1:0] sa);
        logic rd, rdi, wr, wri;
        rd = 1'b0; rdi = 1'b0; wr = 1'b0; wri = 1'b0;
        case (op)
            3'd1: rd = 1'b1;
            3'd2: begin rd = 1'b1; rdi = 1'b1; end
            3'd3: wr = 1'b1;
            3'd4: wri = 1'b1;
            3'd5: begin wri = 1'b1; rd = 1'b1; rdi = 1'b1; end
            default: return 16'h0000;
        endcase
        return {2'b00, rb, ra, rd, rdi, wr, wri, d, sb, sa};
    endfunction

    // Advance to just after the next rising edge. Inputs are changed here.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Mid-cycle output monitor: a valid output must match the queue head, and
    // an output without valid must be all zero.
    task automatic mon();
        logic [15:0] exp;
        #2;
        if (oDecodedValid === 1'b1) begin
            if (sbQ.size() == 0) begin
                check("spurious_valid", {31'd0, oDecodedValid}, 32'd0);
            end else begin
                exp = sbQ.pop_front();
                check("sb_word", {16'd0, oDecodedInstruction}, {16'd0, exp});
            end
        end else begin
            check("idle_word", {16'd0, oDecodedInstruction}, 32'd0);
        end
    endtask

    task automatic drive(input logic [15:0] ins, input logic [15:0] exp);
        iInstr      = ins;
        iInstrValid = 1'b1;
        sbQ.push_back(exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        iReset      = 1'b0;
        iStall      = 1'b0;
        iInstr      = 16'h0000;
        iInstrValid = 1'b0;

        // Reset state
        tick(); mon();
        check("rst_word",  {16'd0, oDecodedInstruction}, 32'd0);
        check("rst_valid", {31'd0, oDecodedValid}, 32'd0);
        check("rst_ready", {31'd0, oInstrReady}, 32'd1);

        // Single WRI, then the word clears
        tick(); iReset = 1'b1;
        drive(mkInstr(3'd4, 4'd5, 1'b1, 1'b0, 2'd2, 2'd3), expWord(3'd4, 4'd5, 1'b1, 1'b0, 2'd2, 2'd3));
        mon();
        check("wri_ready", {31'd0, oInstrReady}, 32'd1);
        tick(); iInstrValid = 1'b0; mon();
        check("wri_valid", {31'd0, oDecodedValid}, 32'd1);
        tick(); mon();
        check("wri_clear_valid", {31'd0, oDecodedValid}, 32'd0);

        // Back-to-back RD, RDI, then a NOP carrying non-zero fields
        tick();
        drive(mkInstr(3'd1, 4'd0, 1'b0, 1'b0, 2'd1, 2'd0), expWord(3'd1, 4'd0, 1'b0, 1'b0, 2'd1, 2'd0));
        mon();
        check("b2b_ready0", {31'd0, oInstrReady}, 32'd1);
        tick();
        drive(mkInstr(3'd2, 4'd0, 1'b1, 1'b1, 2'd3, 2'd0), expWord(3'd2, 4'd0, 1'b1, 1'b1, 2'd3, 2'd0));
        mon();
        check("b2b_ready1", {31'd0, oInstrReady}, 32'd1);
        tick();
        drive(mkInstr(3'd0, 4'd7, 1'b1, 1'b1, 2'd3, 2'd3), 16'h0000);
        mon();
        check("b2b_ready2", {31'd0, oInstrReady}, 32'd1);
        check("b2b_valid2", {31'd0, oDecodedValid}, 32'd1);

        // NOPR cnt=3, with a WR held on the bus that must wait
        tick();
        drive({3'b110, 8'd3, 5'b00000}, 16'h0000);
        mon();
        tick();
        iInstr = mkInstr(3'd3, 4'd9, 1'b0, 1'b1, 2'd0, 2'd2);
        mon();
        check("nopr_valid", {31'd0, oDecodedValid}, 32'd1);
        check("nopr_ready1", {31'd0, oInstrReady}, 32'd0);
        tick(); mon();
        check("nopr_ready2", {31'd0, oInstrReady}, 32'd0);
        check("nopr_rep_valid", {31'd0, oDecodedValid}, 32'd0);
        tick(); mon();
        check("nopr_ready3", {31'd0, oInstrReady}, 32'd0);
        tick();
        sbQ.push_back(expWord(3'd3, 4'd9, 1'b0, 1'b1, 2'd0, 2'd2));
        mon();
        check("nopr_ready4", {31'd0, oInstrReady}, 32'd1);
        tick(); iInstrValid = 1'b0; mon();
        check("nopr_wr_valid", {31'd0, oDecodedValid}, 32'd1);

        // Stall rises on the accepting edge; a competing instruction is ignored
        tick();
        drive(mkInstr(3'd5, 4'd15, 1'b1, 1'b1, 2'd1, 2'd1), expWord(3'd5, 4'd15, 1'b1, 1'b1, 2'd1, 2'd1));
        mon();
        tick();
        iStall = 1'b1;
        iInstr = mkInstr(3'd3, 4'd1, 1'b1, 1'b0, 2'd1, 2'd0);
        mon();
        check("stall_ready1", {31'd0, oInstrReady}, 32'd0);
        check("stall_valid1", {31'd0, oDecodedValid}, 32'd0);
        tick(); mon();
        check("stall_ready2", {31'd0, oInstrReady}, 32'd0);
        check("stall_valid2", {31'd0, oDecodedValid}, 32'd0);
        tick(); iStall = 1'b0; iInstrValid = 1'b0; mon();
        check("stall_present", {31'd0, oDecodedValid}, 32'd1);
        tick(); mon();
        check("stall_once", {31'd0, oDecodedValid}, 32'd0);

        // Asynchronous reset in the middle of a long NOPR repeat
        tick();
        drive({3'b110, 8'd200, 5'b00000}, 16'h0000);
        mon();
        tick(); iInstrValid = 1'b0; mon();
        check("rep_ready1", {31'd0, oInstrReady}, 32'd0);
        tick(); mon();
        check("rep_ready2", {31'd0, oInstrReady}, 32'd0);
        #1 iReset = 1'b0;
        #1;
        check("arst_ready", {31'd0, oInstrReady}, 32'd1);
        check("arst_valid", {31'd0, oDecodedValid}, 32'd0);
        check("arst_word", {16'd0, oDecodedInstruction}, 32'd0);
        tick(); iReset = 1'b1; mon();
        check("arst_ready_rel", {31'd0, oInstrReady}, 32'd1);
        tick();
        drive(mkInstr(3'd1, 4'd12, 1'b0, 1'b1, 2'd2, 2'd1), expWord(3'd1, 4'd12, 1'b0, 1'b1, 2'd2, 2'd1));
        mon();
        tick(); iInstrValid = 1'b0; mon();
        check("post_rst_valid", {31'd0, oDecodedValid}, 32'd1);

        // Illegal opcode 111
        tick();
        drive(mkInstr(3'd7, 4'd6, 1'b1, 1'b1, 2'd2, 2'd2), 16'h0000);
        mon();
`ifdef RF_DEC_ILLEGAL_TRAP_EN
        tick(); iInstrValid = 1'b0; mon();
        check("ill_valid", {31'd0, oDecodedValid}, 32'd1);
        check("ill_flag", {31'd0, oIllegal}, 32'd1);
        check("ill_ready", {31'd0, oInstrReady}, 32'd0);
        tick(); mon();
        check("ill_flag_sticky", {31'd0, oIllegal}, 32'd1);
        check("ill_ready_hold", {31'd0, oInstrReady}, 32'd0);
        #1 iReset = 1'b0;
        #1;
        check("ill_rst_flag", {31'd0, oIllegal}, 32'd0);
        check("ill_rst_ready", {31'd0, oInstrReady}, 32'd1);
        tick(); iReset = 1'b1; mon();
`else
        tick();
        drive(mkInstr(3'd4, 4'd3, 1'b0, 1'b1, 2'd0, 2'd1), expWord(3'd4, 4'd3, 1'b0, 1'b1, 2'd0, 2'd1));
        mon();
        check("ill_valid", {31'd0, oDecodedValid}, 32'd1);
        check("ill_ready", {31'd0, oInstrReady}, 32'd1);
        tick(); iInstrValid = 1'b0; mon();
        check("ill_next_valid", {31'd0, oDecodedValid}, 32'd1);
        tick(); mon();
`endif

        check("sb_drained", sbQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
